// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage hazard controller.
//   Tracks the destinations of instructions in flight past ID, inserts
//   load-use bubbles, squashes wrong-path instructions on a taken branch and
//   produces registered forwarding selects for the EX operand muxes.
//
// Parameters
//   RA_W          register address width
//   LOAD_BUBBLES  bubbles inserted on a load-use hazard (legal 1..3)
//   CNT_W         perf counter width (present only with HAZ_PERF_CNT_EN)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs1/id_rs2              ID source addresses
//   id_use_rs1/id_use_rs2      ID instruction reads rs1/rs2
//   id_wa, id_regWrite         ID destination address / writes regfile
//   id_is_load                 ID instruction is a load
//   ex_br_taken                branch in EX redirects this cycle
//   stall                      hold PC and IF/ID (combinational)
//   flush_id                   clear IF/ID at next edge (combinational)
//   flush_ex                   bubble into ID/EX at next edge (combinational)
//   rs1_sel/rs2_sel            forward select: 0 reg, 1 mem_wd, 2 wb_wd (registered)
//   perf_stall/perf_flush      stall-cycle / taken-branch counters
//
// Build option
//   HAZ_PERF_CNT_EN  adds CNT_W and the perf_stall/perf_flush counters.
module ex_hazard_ctrl #(
  parameter int unsigned RA_W         = 5,
  parameter int unsigned LOAD_BUBBLES = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_wa,
  input  logic            id_regWrite,
  input  logic            id_is_load,
  input  logic            ex_br_taken,
  output logic            stall,
  output logic            flush_id,
  output logic            flush_ex,
  output logic [1:0]      rs1_sel,
  output logic [1:0]      rs2_sel
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_stall
  , output logic [CNT_W-1:0] perf_flush
`endif
);

  localparam int unsigned BUB_W = 2;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LD_STALL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BUB_W-1:0]   bub_cnt_q, bub_cnt_d;

  // EX shadow entry {v, wa, wr, ld}
  logic               ex_v_q, ex_v_d;
  logic [RA_W-1:0]    ex_wa_q, ex_wa_d;
  logic               ex_wr_q, ex_wr_d;
  logic               ex_ld_q, ex_ld_d;

  // MEM shadow entry. The load flag is not kept because a load in MEM forwards
  // like any other writer, and no WB entry is kept because an entry leaving
  // MEM has already had its only visible effect (select 2) decided.
  logic               mem_v_q;
  logic [RA_W-1:0]    mem_wa_q;
  logic               mem_wr_q;

  logic [1:0]         rs1_sel_q, rs1_sel_d;
  logic [1:0]         rs2_sel_q, rs2_sel_d;

  logic               writer_ex;
  logic               writer_mem;
  logic               fwd_ex_ok;
  logic               hit_ld;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]   perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0]   perf_flush_q, perf_flush_d;
`endif

  // Hazard detection against the in-flight entries; x0 never hazards.
  always_comb begin
    writer_ex  = ex_v_q & ex_wr_q & (ex_wa_q != '0);
    writer_mem = mem_v_q & mem_wr_q & (mem_wa_q != '0);
    fwd_ex_ok  = writer_ex & ~ex_ld_q;
    hit_ld     = id_valid & ex_ld_q & writer_ex &
                 ((id_use_rs1 & (id_rs1 == ex_wa_q)) |
                  (id_use_rs2 & (id_rs2 == ex_wa_q)));
  end

  // Next state and pipeline-control outputs; a taken branch beats load-use.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    stall     = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_br_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (hit_ld) begin
          stall    = 1'b1;
          flush_ex = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d   = ST_LD_STALL;
            bub_cnt_d = BUB_W'(LOAD_BUBBLES - 1);
          end
        end
      end
      ST_LD_STALL: begin
        if (ex_br_taken) begin
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          state_d   = ST_RUN;
          bub_cnt_d = '0;
        end else begin
          stall     = 1'b1;
          flush_ex  = 1'b1;
          bub_cnt_d = bub_cnt_q - BUB_W'(1);
          if (bub_cnt_q == BUB_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d   = ST_RUN;
        bub_cnt_d = '0;
      end
    endcase
  end

  // Next EX entry and forward selects for the instruction now in ID.
  always_comb begin
    ex_v_d  = id_valid & ~flush_ex;
    ex_wa_d = flush_ex ? '0 : id_wa;
    ex_wr_d = id_regWrite & ~flush_ex;
    ex_ld_d = id_is_load & ~flush_ex;

    rs1_sel_d = 2'd0;
    rs2_sel_d = 2'd0;
    if (!flush_ex) begin
      if (id_use_rs1 & fwd_ex_ok & (id_rs1 == ex_wa_q)) begin
        rs1_sel_d = 2'd1;
      end else if (id_use_rs1 & writer_mem & (id_rs1 == mem_wa_q)) begin
        rs1_sel_d = 2'd2;
      end
      if (id_use_rs2 & fwd_ex_ok & (id_rs2 == ex_wa_q)) begin
        rs2_sel_d = 2'd1;
      end else if (id_use_rs2 & writer_mem & (id_rs2 == mem_wa_q)) begin
        rs2_sel_d = 2'd2;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Event counters, wrapping naturally at 2^CNT_W.
  always_comb begin
    perf_stall_d = perf_stall_q + CNT_W'(stall);
    perf_flush_d = perf_flush_q + CNT_W'(ex_br_taken);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      bub_cnt_q    <= '0;
      ex_v_q       <= 1'b0;
      ex_wa_q      <= '0;
      ex_wr_q      <= 1'b0;
      ex_ld_q      <= 1'b0;
      mem_v_q      <= 1'b0;
      mem_wa_q     <= '0;
      mem_wr_q     <= 1'b0;
      rs1_sel_q    <= 2'd0;
      rs2_sel_q    <= 2'd0;
`ifdef HAZ_PERF_CNT_EN
      perf_stall_q <= '0;
      perf_flush_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bub_cnt_q    <= bub_cnt_d;
      ex_v_q       <= ex_v_d;
      ex_wa_q      <= ex_wa_d;
      ex_wr_q      <= ex_wr_d;
      ex_ld_q      <= ex_ld_d;
      mem_v_q      <= ex_v_q;
      mem_wa_q     <= ex_wa_q;
      mem_wr_q     <= ex_wr_q;
      rs1_sel_q    <= rs1_sel_d;
      rs2_sel_q    <= rs2_sel_d;
`ifdef HAZ_PERF_CNT_EN
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
`endif
    end
  end

  assign rs1_sel = rs1_sel_q;
  assign rs2_sel = rs2_sel_q;
`ifdef HAZ_PERF_CNT_EN
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: one instance with LOAD_BUBBLES=1 (suffix 1)
// and one with LOAD_BUBBLES=3 (suffix 3) driven by the same ID/EX inputs.
module tb_ex_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_wa;
  logic       id_regWrite;
  logic       id_is_load;
  logic       ex_br_taken;

  logic       s1, fi1, fe1;
  logic [1:0] r1s1, r2s1;
  logic       s3, fi3, fe3;
  logic [1:0] r1s3, r2s3;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] ps1, pf1, ps3, pf3;
`endif

  int pass_cnt;
  int chk_cnt;

  ex_hazard_ctrl #(.RA_W(5), .LOAD_BUBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wa(id_wa), .id_regWrite(id_regWrite), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken),
    .stall(s1), .flush_id(fi1), .flush_ex(fe1),
    .rs1_sel(r1s1), .rs2_sel(r2s1)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall(ps1), .perf_flush(pf1)
`endif
  );

  ex_hazard_ctrl #(.RA_W(5), .LOAD_BUBBLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_wa(id_wa), .id_regWrite(id_regWrite), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken),
    .stall(s3), .flush_id(fi3), .flush_ex(fe3),
    .rs1_sel(r1s3), .rs2_sel(r2s3)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall(ps3), .perf_flush(pf3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] wa,
                     input logic rw, input logic ld, input logic br);
    id_valid    = v;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_wa       = wa;
    id_regWrite = rw;
    id_is_load  = ld;
    ex_br_taken = br;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL rst_stall1 got %0b exp 0", s1); else pass_cnt++;
    chk_cnt++; if (fi1 !== 1'b0) $display("FAIL rst_flush_id1 got %0b exp 0", fi1); else pass_cnt++;
    chk_cnt++; if (fe1 !== 1'b0) $display("FAIL rst_flush_ex1 got %0b exp 0", fe1); else pass_cnt++;
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL rst_rs1_sel1 got %0d exp 0", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s1 !== 2'd0) $display("FAIL rst_rs2_sel1 got %0d exp 0", r2s1); else pass_cnt++;
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL rst_stall3 got %0b exp 0", s3); else pass_cnt++;
`ifdef HAZ_PERF_CNT_EN
    chk_cnt++; if (ps1 !== 32'd0) $display("FAIL rst_perf_stall1 got %0d exp 0", ps1); else pass_cnt++;
    chk_cnt++; if (pf1 !== 32'd0) $display("FAIL rst_perf_flush1 got %0d exp 0", pf1); else pass_cnt++;
`endif
  endtask

  task automatic test_forward();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);           // add x5
    tick();
    drv(1, 5'd5, 1, 5'd7, 1, 5'd8, 1, 0, 0);           // add x8 <- x5, x7
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL fwd_stall got %0b exp 0", s1); else pass_cnt++;
    chk_cnt++; if (fe1 !== 1'b0) $display("FAIL fwd_flush_ex got %0b exp 0", fe1); else pass_cnt++;
    tick();
    chk_cnt++; if (r1s1 !== 2'd1) $display("FAIL fwd_ex_rs1 got %0d exp 1", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s1 !== 2'd0) $display("FAIL fwd_ex_rs2 got %0d exp 0", r2s1); else pass_cnt++;
    drv(1, 5'd8, 1, 5'd5, 1, 5'd0, 0, 0, 0);           // reads x8 (EX) and x5 (MEM)
    tick();
    chk_cnt++; if (r1s1 !== 2'd1) $display("FAIL fwd_mix_rs1 got %0d exp 1", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s1 !== 2'd2) $display("FAIL fwd_mix_rs2 got %0d exp 2", r2s1); else pass_cnt++;
    chk_cnt++; if (r2s3 !== 2'd2) $display("FAIL fwd_mix_rs2_3 got %0d exp 2", r2s3); else pass_cnt++;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0);           // add x9
    tick();
    tick();                                              // add x9 again
    drv(1, 5'd9, 1, 5'd9, 0, 5'd0, 0, 0, 0);           // rs1=x9 used, rs2=x9 unused
    tick();
    chk_cnt++; if (r1s1 !== 2'd1) $display("FAIL fwd_mem_prio got %0d exp 1", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s1 !== 2'd0) $display("FAIL fwd_use_gate got %0d exp 0", r2s1); else pass_cnt++;
    tick();                                              // x9 now only in MEM
    chk_cnt++; if (r1s1 !== 2'd2) $display("FAIL fwd_wb got %0d exp 2", r1s1); else pass_cnt++;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd10, 0, 0, 0);          // x10 with regWrite=0
    tick();
    drv(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL fwd_nowrite got %0d exp 0", r1s1); else pass_cnt++;
    drv(0, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 0);          // invalid slot naming x11
    tick();
    drv(1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL fwd_invalid got %0d exp 0", r1s1); else pass_cnt++;
    drain();
  endtask

  task automatic test_load_use();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);           // lw x6
    tick();
    drv(1, 5'd6, 0, 5'd6, 1, 5'd0, 0, 0, 0);           // consumer reads rs2=x6
    settle();
    chk_cnt++; if (s1 !== 1'b1) $display("FAIL lu_stall1_c1 got %0b exp 1", s1); else pass_cnt++;
    chk_cnt++; if (fe1 !== 1'b1) $display("FAIL lu_flush_ex1 got %0b exp 1", fe1); else pass_cnt++;
    chk_cnt++; if (fi1 !== 1'b0) $display("FAIL lu_flush_id1 got %0b exp 0", fi1); else pass_cnt++;
    chk_cnt++; if (s3 !== 1'b1) $display("FAIL lu_stall3_c1 got %0b exp 1", s3); else pass_cnt++;
    tick();
    chk_cnt++; if (r2s1 !== 2'd0) $display("FAIL lu_bubble_sel got %0d exp 0", r2s1); else pass_cnt++;
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL lu_stall1_c2 got %0b exp 0", s1); else pass_cnt++;
    chk_cnt++; if (s3 !== 1'b1) $display("FAIL lu_stall3_c2 got %0b exp 1", s3); else pass_cnt++;
    tick();
    chk_cnt++; if (r2s1 !== 2'd2) $display("FAIL lu_wb_fwd got %0d exp 2", r2s1); else pass_cnt++;
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL lu_rs1_unused got %0d exp 0", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s3 !== 2'd0) $display("FAIL lu_sel3_stall got %0d exp 0", r2s3); else pass_cnt++;
    idle();
    settle();
    chk_cnt++; if (s3 !== 1'b1) $display("FAIL lu_stall3_c3 got %0b exp 1", s3); else pass_cnt++;
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL lu_stall1_c3 got %0b exp 0", s1); else pass_cnt++;
    tick();
    settle();
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL lu_stall3_c4 got %0b exp 0", s3); else pass_cnt++;
    drain();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);           // lw x7
    tick();
    drv(1, 5'd7, 1, 5'd3, 0, 5'd0, 0, 0, 0);           // reads rs1=x7
    settle();
    chk_cnt++; if (s1 !== 1'b1) $display("FAIL lu_rs1_stall got %0b exp 1", s1); else pass_cnt++;
    drain();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);           // lw x6
    tick();
    drv(0, 5'd6, 1, 5'd6, 1, 5'd0, 0, 0, 0);           // ID empty but addresses match
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL lu_id_invalid got %0b exp 0", s1); else pass_cnt++;
    drain();
  endtask

  task automatic test_branch();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);           // lw x6
    tick();
    drv(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 1);           // load-use plus taken branch
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL br_stall1 got %0b exp 0", s1); else pass_cnt++;
    chk_cnt++; if (fi1 !== 1'b1) $display("FAIL br_flush_id1 got %0b exp 1", fi1); else pass_cnt++;
    chk_cnt++; if (fe1 !== 1'b1) $display("FAIL br_flush_ex1 got %0b exp 1", fe1); else pass_cnt++;
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL br_stall3 got %0b exp 0", s3); else pass_cnt++;
    tick();
    idle();
    settle();
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL br_run3 got %0b exp 0", s3); else pass_cnt++;
    chk_cnt++; if (fe3 !== 1'b0) $display("FAIL br_run3_fe got %0b exp 0", fe3); else pass_cnt++;
    tick();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);           // add x5
    tick();
    drv(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 1);           // would forward, but squashed
    tick();
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL br_sel_squash got %0d exp 0", r1s1); else pass_cnt++;
    drain();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);           // lw x6
    tick();
    drv(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 0);
    tick();                                              // dut3 now in extra bubbles
    drv(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 1);
    settle();
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL br_ldst_stall3 got %0b exp 0", s3); else pass_cnt++;
    chk_cnt++; if (fi3 !== 1'b1) $display("FAIL br_ldst_fid3 got %0b exp 1", fi3); else pass_cnt++;
    chk_cnt++; if (fe3 !== 1'b1) $display("FAIL br_ldst_fex3 got %0b exp 1", fe3); else pass_cnt++;
    tick();
    idle();
    settle();
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL br_ldst_exit3 got %0b exp 0", s3); else pass_cnt++;
    drain();
  endtask

  task automatic test_x0();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0);           // write x0
    tick();
    tick();                                              // x0 writers in EX and MEM
    drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL x0_stall got %0b exp 0", s1); else pass_cnt++;
    tick();
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL x0_rs1 got %0d exp 0", r1s1); else pass_cnt++;
    chk_cnt++; if (r2s1 !== 2'd0) $display("FAIL x0_rs2 got %0d exp 0", r2s1); else pass_cnt++;
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);           // lw x0
    tick();
    drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
    settle();
    chk_cnt++; if (s1 !== 1'b0) $display("FAIL x0_load_stall1 got %0b exp 0", s1); else pass_cnt++;
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL x0_load_stall3 got %0b exp 0", s3); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0);           // add x5
    tick();
    drv(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0);
    tick();
    chk_cnt++; if (r1s3 !== 2'd1) $display("FAIL rstm_pre_sel got %0d exp 1", r1s3); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (r1s1 !== 2'd0) $display("FAIL rstm_async_sel1 got %0d exp 0", r1s1); else pass_cnt++;
    chk_cnt++; if (r1s3 !== 2'd0) $display("FAIL rstm_async_sel3 got %0d exp 0", r1s3); else pass_cnt++;
    idle();
    @(negedge clk) rst_n = 1'b1;
    tick();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);           // lw x6
    tick();
    drv(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 0);
    settle();
    chk_cnt++; if (s3 !== 1'b1) $display("FAIL rstm_c1 got %0b exp 1", s3); else pass_cnt++;
    tick();
    settle();
    chk_cnt++; if (s3 !== 1'b1) $display("FAIL rstm_c2 got %0b exp 1", s3); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL rstm_stall_clr got %0b exp 0", s3); else pass_cnt++;
    chk_cnt++; if (fe3 !== 1'b0) $display("FAIL rstm_fe_clr got %0b exp 0", fe3); else pass_cnt++;
    chk_cnt++; if (r2s3 !== 2'd0) $display("FAIL rstm_sel_clr got %0d exp 0", r2s3); else pass_cnt++;
    idle();
    @(negedge clk) rst_n = 1'b1;
    tick();
    settle();
    chk_cnt++; if (s3 !== 1'b0) $display("FAIL rstm_run got %0b exp 0", s3); else pass_cnt++;
    drain();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (ps3 !== 32'd0) $display("FAIL perf_rst_stall got %0d exp 0", ps3); else pass_cnt++;
    chk_cnt++; if (pf3 !== 32'd0) $display("FAIL perf_rst_flush got %0d exp 0", pf3); else pass_cnt++;
    idle();
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 1, 0);
      tick();
      drv(1, 5'd0, 0, 5'd6, 1, 5'd0, 0, 0, 0);
      tick(); tick(); tick();
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
      tick();
      idle();
      tick();
    end
    chk_cnt++; if (ps1 !== 32'd2) $display("FAIL perf_stall1 got %0d exp 2", ps1); else pass_cnt++;
    chk_cnt++; if (pf1 !== 32'd3) $display("FAIL perf_flush1 got %0d exp 3", pf1); else pass_cnt++;
    chk_cnt++; if (ps3 !== 32'd6) $display("FAIL perf_stall3 got %0d exp 6", ps3); else pass_cnt++;
    chk_cnt++; if (pf3 !== 32'd3) $display("FAIL perf_flush3 got %0d exp 3", pf3); else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    rst_n    = 1'b0;
    idle();
    #2;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    test_forward();
    test_load_use();
    test_branch();
    test_x0();
    test_reset_mid_stall();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
